imem_sync: RTL

- Parametrised next-generation instruction memory for the LEGv8 core.
  - Word width and depth are configurable.
  - Reads are synchronous, use a valid/ready request handshake and have a configurable wait-state latency.
- A runtime program-load port replaces the fixed ROM image.
- Misaligned and out-of-range fetches are flagged instead of aliasing.
- Sits between the fetch stage (PC) and the instruction decoder; also serves multicycle/pipelined datapaths.

---
 rtl/imem_sync.sv | 104 ++++++++++
 1 files changed

// File: rtl/imem_sync.sv
// Synchronous instruction memory with a valid/ready fetch port, programmable wait states,
// a runtime program-load port and misaligned/out-of-range fault reporting.
module imem_sync #(
    parameter int N         = 32,
    parameter int DEPTH     = 64,
    parameter int AW        = $clog2(DEPTH),
    parameter int WAIT      = 0,
    parameter     INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [63:0]   req_addr,
    output logic          rsp_valid,
    output logic [N-1:0]  rsp_data,
    output logic          rsp_fault,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [N-1:0]  prog_data,
    output logic          busy
);

    // Handshake: a request transfers at a rising edge where req_valid && req_ready;
    // the requester holds req_valid/req_addr until then, nothing is queued.
    // rsp_valid is a one-cycle pulse; rsp_data/rsp_fault hold between pulses.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [63:0]   addr_q;
    logic [63:0]   fetch_addr;
    logic          accept;
    logic          fault;
    logic [N-1:0]  mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    assign req_ready = !reset && (state != S_WAIT);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state == S_WAIT);

    // With no wait states the memory is read at the accept edge, so use the live address.
    assign fetch_addr = (state == S_WAIT) ? addr_q : req_addr;
    assign fault      = (fetch_addr[1:0] != 2'b00) || (|fetch_addr[63:AW+2]);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    if (WAIT == 0) begin
                        state_n = S_RESP;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = WAIT_LD;
                    end
                end else if (state == S_RESP) begin
                    state_n = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_n = S_RESP;
                else             cnt_n   = cnt - 4'd1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            addr_q    <= 64'd0;
            rsp_data  <= '0;
            rsp_fault <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) addr_q <= req_addr;
            if (state_n == S_RESP) begin
                rsp_fault <= fault;
                rsp_data  <= fault ? '0 : mem[fetch_addr[AW+1:2]];
            end
        end
    end

    // Separate write process: a same-edge read above sees the old word.
    always_ff @(posedge clk) begin
        if (!reset && prog_we) mem[prog_addr] <= prog_data;
    end

endmodule
